fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 48 ++++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle of the fetch stage's external handshakes.
//   redirect_valid/redirect_pc           : new fetch target from next-PC logic
//   imem_req_valid/ready/addr            : in-order instruction memory requests
//   imem_resp_valid/data                 : in-order responses, always accepted
//   if_valid/ready/pc/instr/pc_plus4     : instruction stream to decode
//   if_misalign                          : only with FETCH_MISALIGN_EN defined
// modport master: the fetch unit; modport slave: its environment.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_EN
  logic        if_misalign;
`endif

  modport master (
`ifdef FETCH_MISALIGN_EN
    output if_misalign,
`endif
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output if_valid, if_pc, if_instr, if_pc_plus4,
    input  if_ready
  );

  modport slave (
`ifdef FETCH_MISALIGN_EN
    input  if_misalign,
`endif
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  if_valid, if_pc, if_instr, if_pc_plus4,
    output if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the fetch PC, issues in-order requests to instruction memory, buffers
// returned instructions in a FIFO_DEPTH-entry FIFO and presents them to decode.
// A redirect flushes the FIFO and discards responses of in-flight requests.
// Ports: clk, rst (synchronous, active-high), bus (fetch_unit_if.master).
// Parameters: RESET_PC (fetch PC after reset), FIFO_DEPTH (buffer entries and
// outstanding-request cap, power of 2, >= 2).
// Optional macro FETCH_MISALIGN_EN: a misaligned redirect target issues no
// requests; after draining, one nop entry flagged if_misalign is presented.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];

  logic          req_valid, accept, credit;
  logic          resp_keep, resp_drop, push, pop;
  logic [31:0]   redir_pc, push_pc, push_instr;
  logic [CW:0]   used;

`ifdef FETCH_MISALIGN_EN
  logic          mis_mem_q [FIFO_DEPTH];
  logic          pend_q, pend_d, idle_q, idle_d, misal_redir, pseudo_push;
  assign redir_pc    = bus.redirect_pc;
  assign misal_redir = bus.redirect_pc[1:0] != 2'b00;
  assign pseudo_push = pend_q && (disc_q == '0);
`else
  assign redir_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  assign used      = {1'b0, out_q} + {1'b0, cnt_q};
  assign credit    = used < (CW+1)'(FIFO_DEPTH);
  assign accept    = req_valid && bus.imem_req_ready;
  assign resp_keep = bus.imem_resp_valid && (disc_q == '0);
  assign resp_drop = bus.imem_resp_valid && (disc_q != '0);
  assign pop       = (cnt_q != '0) && bus.if_ready;

`ifdef FETCH_MISALIGN_EN
  assign push       = resp_keep || pseudo_push;
  assign push_pc    = pseudo_push ? fetch_pc_q : resp_pc_q;
  assign push_instr = pseudo_push ? 32'h0000_0013 : bus.imem_resp_data;
`else
  assign push       = resp_keep;
  assign push_pc    = resp_pc_q;
  assign push_instr = bus.imem_resp_data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: DRAIN while stale responses remain to be discarded
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (disc_d != '0) state_d = DRAIN;
      DRAIN:   if (disc_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs: request credit and flow control
  always_comb begin
    req_valid = !rst && !bus.redirect_valid && credit;
`ifdef FETCH_MISALIGN_EN
    req_valid = req_valid && !idle_q;
`endif
  end

  // Datapath next-state
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(bus.imem_resp_valid);
    disc_d     = disc_q - CW'(resp_drop);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    if (accept)    fetch_pc_d = fetch_pc_q + 32'd4;
    if (resp_keep) resp_pc_d  = resp_pc_q + 32'd4;
    if (bus.redirect_valid) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      // out_q counts every in-flight request, including ones already marked
      // for discard, so after a redirect all of them (less this cycle's
      // response) are stale.
      disc_d     = out_q - CW'(bus.imem_resp_valid);
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_comb begin
    pend_d = pend_q && !pseudo_push;
    idle_d = idle_q;
    if (bus.redirect_valid) begin
      pend_d = misal_redir;
      idle_d = misal_redir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      idle_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      idle_q <= idle_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]    <= push_pc;
      instr_mem_q[wr_q] <= push_instr;
`ifdef FETCH_MISALIGN_EN
      mis_mem_q[wr_q]   <= pseudo_push;
`endif
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = !rst && (cnt_q != '0);
  assign bus.if_pc          = pc_mem_q[rd_q];
  assign bus.if_instr       = instr_mem_q[rd_q];
  assign bus.if_pc_plus4    = pc_mem_q[rd_q] + 32'd4;
`ifdef FETCH_MISALIGN_EN
  assign bus.if_misalign    = !rst && (cnt_q != '0) && mis_mem_q[rd_q];
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A memory model answers
// accepted requests in order (one-cycle latency unless held); a monitor pushes
// the expected instruction for each accepted request and compares each entry
// decode consumes. Directed sequences add targeted checks.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] pend[$];
  logic        mem_hold = 1'b0;
  logic [31:0] exp_req_addr = 32'h0;
  int          pop_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] last_pc, last_instr, last_p4, last_acc_addr;
  logic        mem_d;
  logic [31:0] mem_rd;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: responses in request order, next cycle unless held
  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_d  = 1'b0;
      mem_rd = '0;
      if (rst) pend.delete();
      else begin
        if (bus.imem_req_valid && bus.imem_req_ready) pend.push_back(bus.imem_req_addr);
        if (!mem_hold && pend.size() > 0) begin
          mem_d  = 1'b1;
          mem_rd = memfn(pend.pop_front());
        end
      end
      @(posedge clk);
      #1;
      bus.imem_resp_valid = mem_d;
      bus.imem_resp_data  = mem_rd;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_req_addr = 32'h0;
    end else begin
      if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
        pop_cnt++;
        last_pc    = bus.if_pc;
        last_instr = bus.if_instr;
        last_p4    = bus.if_pc_plus4;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_pop: got pc %h expected no instruction", bus.if_pc);
        end else begin
          e = sb.pop_front();
          check("sb_if_pc", bus.if_pc, e.pc);
          check("sb_if_instr", bus.if_instr, e.instr);
          check("sb_if_pc_plus4", bus.if_pc_plus4, e.pc + 32'd4);
`ifdef FETCH_MISALIGN_EN
          check("sb_if_misalign", 32'(bus.if_misalign), 32'(e.mis));
`endif
        end
      end
      if (bus.redirect_valid) begin
        sb.delete();
        exp_req_addr = bus.redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_EN
        if (bus.redirect_pc[1:0] != 2'b00) begin
          e.pc    = bus.redirect_pc;
          e.instr = 32'h0000_0013;
          e.mis   = 1'b1;
          sb.push_back(e);
        end
`endif
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        acc_cnt++;
        last_acc_addr = bus.imem_req_addr;
        check("sb_req_addr", bus.imem_req_addr, exp_req_addr);
        e.pc    = exp_req_addr;
        e.instr = memfn(exp_req_addr);
        e.mis   = 1'b0;
        sb.push_back(e);
        exp_req_addr = exp_req_addr + 32'd4;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] pc,
                          input logic [31:0] instr, input logic [31:0] p4);
    int start = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == start; i++) tick();
    if (pop_cnt == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no instruction expected pc %h", name, pc);
    end else begin
      check({name, "_pc"}, last_pc, pc);
      check({name, "_instr"}, last_instr, instr);
      check({name, "_pc_plus4"}, last_p4, p4);
    end
  endtask

  task automatic wait_acc(input string name, input logic [31:0] addr);
    int start = acc_cnt;
    for (int i = 0; i < 30 && acc_cnt == start; i++) tick();
    if (acc_cnt == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no request expected addr %h", name, addr);
    end else check(name, last_acc_addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_c, val_c, a0;
    logic [31:0] f_pc, f_p4, f_instr;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;

    // Basic streaming and first-instruction latency
    do_reset();
    acc_c = -1;
    val_c = -1;
    f_pc = '0; f_p4 = '0; f_instr = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (acc_c < 0 && bus.imem_req_valid && bus.imem_req_ready) acc_c = c;
      if (val_c < 0 && bus.if_valid) begin
        val_c = c;
        f_pc = bus.if_pc; f_p4 = bus.if_pc_plus4; f_instr = bus.if_instr;
      end
      tick();
    end
    check("t1_first_acc_cycle", 32'(acc_c), 32'd0);
    check("t1_latency", 32'(val_c - acc_c), 32'd2);
    check("t1_first_pc", f_pc, 32'h0000_0000);
    check("t1_first_pc_plus4", f_p4, 32'h0000_0004);
    check("t1_first_instr", f_instr, 32'h0000_FFFF);
    repeat (10) tick();

    // Decode stalled: credits cap accepted requests at FIFO_DEPTH
    bus.if_ready = 1'b0;
    do_reset();
    a0 = acc_cnt;
    repeat (10) tick();
    check("t2_accepts", 32'(acc_cnt - a0), 32'd2);
    @(negedge clk);
    check("t2_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.if_ready = 1'b1;
    wait_pop("t2_pop0", 32'h0, 32'h0000_FFFF, 32'h4);
    wait_pop("t2_pop1", 32'h4, 32'h0004_FFFB, 32'h8);
    wait_pop("t2_pop2", 32'h8, 32'h0008_FFF7, 32'hC);

    // Memory back-pressure: address held until accepted
    bus.imem_req_ready = 1'b0;
    do_reset();
    redirect(32'h0000_0010);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t3_hold_addr", bus.imem_req_addr, 32'h0000_0010);
      tick();
    end
    bus.imem_req_ready = 1'b1;
    wait_acc("t3_acc0", 32'h0000_0010);
    wait_acc("t3_acc1", 32'h0000_0014);
    repeat (4) tick();

    // Redirect with two requests outstanding: both responses dropped
    mem_hold = 1'b1;
    do_reset();
    redirect(32'h0000_0020);
    tick();
    tick();
    redirect(32'h0000_0100);
    mem_hold = 1'b0;
    wait_pop("t4_target", 32'h0000_0100, 32'h0100_FEFF, 32'h0000_0104);
    repeat (4) tick();

    // Redirect coinciding with a response and a pop
    bus.if_ready = 1'b0;
    mem_hold = 1'b1;
    do_reset();
    redirect(32'h0000_0200);
    tick();
    mem_hold = 1'b0;
    tick();
    tick();
    mem_hold = 1'b1;
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    check("t5_resp_same_cycle", 32'(bus.imem_resp_valid), 32'd1);
    check("t5_pop_same_cycle", 32'(bus.if_valid), 32'd1);
    tick();
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    check("t5_if_valid_flushed", 32'(bus.if_valid), 32'd0);
    check("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t5_req_addr", bus.imem_req_addr, 32'h0000_0300);
    tick();
    wait_pop("t5_target", 32'h0000_0300, 32'h0300_FCFF, 32'h0000_0304);
    repeat (4) tick();

    // Fetch PC wrap-around
    do_reset();
    redirect(32'hFFFF_FFFC);
    wait_acc("t6_acc_top", 32'hFFFF_FFFC);
    wait_acc("t6_acc_wrap", 32'h0000_0000);
    wait_pop("t6_top", 32'hFFFF_FFFC, 32'hFFFC_0003, 32'h0000_0000);
    repeat (4) tick();

    // Misaligned redirect target
    do_reset();
`ifdef FETCH_MISALIGN_EN
    redirect(32'h0000_0102);
    a0 = acc_cnt;
    wait_pop("t7_misalign", 32'h0000_0102, 32'h0000_0013, 32'h0000_0106);
    repeat (6) tick();
    check("t7_no_requests", 32'(acc_cnt - a0), 32'd0);
    @(negedge clk);
    check("t7_idle", 32'(bus.imem_req_valid), 32'd0);
    tick();
`else
    redirect(32'h0000_0203);
    wait_acc("t7_masked_acc", 32'h0000_0200);
    wait_pop("t7_masked", 32'h0000_0200, 32'h0200_FDFF, 32'h0000_0204);
`endif
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
